// File: rtl/ddr3_frame_reader.sv
`default_nettype none
// ============================================================================
//  Module      : ddr3_frame_reader
//  Description : AXI read-channel initiator that fetches one frame from the
//                DDR3 controller in bursts of up to BURST_LEN beats. The
//                returned data goes into a show-ahead FIFO and leaves as a
//                valid/ready stream. Bursts are issued only when FIFO space
//                is already reserved, because the R channel has no ready.
//                Optional burst-framing checker enabled by the macro
//                DDR3_FRAME_READER_RLAST_CHECK_EN (drives o_err).
//  Revision    : 1.0 - initial release
// ============================================================================
module ddr3_frame_reader #(
   parameter logic [27:0] BASE_ADDR   = 28'h0,
   parameter int          FRAME_BEATS = 1920,
   parameter int          BURST_LEN   = 16,
   parameter int          ADDR_STEP   = 8,
   parameter int          FIFO_DEPTH  = 64
) (
   input  logic          clk,
   input  logic          rstn,
   input  logic          i_inited,
   input  logic          i_start,
   output logic          o_busy,
   output logic          o_done,
   output logic          o_err,
   output logic [27:0]   axi_araddr,
   output logic [3:0]    axi_arlen,
   output logic          axi_arvalid,
   input  logic          axi_arready,
   input  logic [127:0]  axi_rdata,
   input  logic [3:0]    axi_rid,
   input  logic          axi_rlast,
   input  logic          axi_rvalid,
   output logic [127:0]  o_data,
   output logic          o_valid,
   input  logic          i_ready
);

   // Counter widths are padded to at least 5 bits so a burst length
   // (1..16) always fits without truncation.
   localparam int c_AW  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int c_CW0 = $clog2(FIFO_DEPTH) + 1;
   localparam int c_CW  = (c_CW0 < 5) ? 5 : c_CW0;
   localparam int c_RW0 = $clog2(FRAME_BEATS + 1);
   localparam int c_RW  = (c_RW0 < 5) ? 5 : c_RW0;

   localparam logic [1:0] c_IDLE  = 2'd0;
   localparam logic [1:0] c_ISSUE = 2'd1;
   localparam logic [1:0] c_DRAIN = 2'd2;
   localparam logic [1:0] c_DONE  = 2'd3;

   // ------------------------------------------------------------------------
   // Internal reset: asserts asynchronously, releases synchronously
   // ------------------------------------------------------------------------
   logic r_rst_meta;
   logic r_rst_n;

   // Two-flop release synchroniser for the internal reset
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_rst_meta <= 1'b0;
         r_rst_n    <= 1'b0;
      end else begin
         r_rst_meta <= 1'b1;
         r_rst_n    <= r_rst_meta;
      end
   end

   // ------------------------------------------------------------------------
   // State and bookkeeping
   // ------------------------------------------------------------------------
   logic [1:0]       r_state;
   logic [27:0]      r_addr;
   logic [c_RW-1:0]  r_remaining;
   logic [c_CW-1:0]  r_outstanding;
   logic [c_CW-1:0]  r_count;
   logic [c_AW-1:0]  r_wr_ptr;
   logic [c_AW-1:0]  r_rd_ptr;
   logic [127:0]     r_mem [FIFO_DEPTH];

   logic [4:0]       w_this_len;
   logic [c_CW-1:0]  w_len_ext;
   logic [c_CW-1:0]  w_credit;
   logic [c_CW-1:0]  w_out_add;
   logic [c_CW-1:0]  w_out_sub;
   logic [27:0]      w_addr_inc;
   logic             w_ar_ok;
   logic             w_ar_hs;
   logic             w_beat_acc;
   logic             w_valid;
   logic             w_pop;
   logic             w_unused_rid;

   // Length of the next burst: a full burst, or whatever is left of the frame
   always_comb begin
      w_this_len = 5'(BURST_LEN);
      if (r_remaining < c_RW'(BURST_LEN)) begin
         w_this_len = r_remaining[4:0];
      end
   end

   assign w_len_ext  = c_CW'(w_this_len);
   // Free space not yet promised to any beat; it only grows between issues,
   // so once arvalid rises it stays up until the handshake.
   assign w_credit   = c_CW'(FIFO_DEPTH) - r_count - r_outstanding;
   assign w_ar_ok    = (r_state == c_ISSUE) && (r_remaining != '0) &&
                       (w_credit >= w_len_ext);
   assign w_ar_hs    = w_ar_ok && axi_arready;
   assign w_addr_inc = 28'(w_this_len) * 28'(ADDR_STEP);

   // A beat is only taken while a frame owns the channel and beats are due;
   // anything else would land in space that was never reserved.
   assign w_beat_acc = axi_rvalid && (r_state != c_IDLE) && (r_outstanding != '0);
   assign w_valid    = (r_count != '0);
   assign w_pop      = w_valid && i_ready;

   assign w_out_add  = w_ar_hs ? w_len_ext : '0;
   assign w_out_sub  = w_beat_acc ? c_CW'(1) : '0;

   assign axi_arvalid = w_ar_ok;
   assign axi_araddr  = w_ar_ok ? r_addr : '0;
   assign axi_arlen   = w_ar_ok ? 4'(w_this_len - 5'd1) : '0;

   assign o_busy  = (r_state == c_ISSUE) || (r_state == c_DRAIN);
   assign o_done  = (r_state == c_DONE);
   assign o_valid = w_valid;
   assign o_data  = w_valid ? r_mem[r_rd_ptr] : '0;

   assign w_unused_rid = ^axi_rid;

   // Frame sequencing: start, burst issue, drain of in-flight beats, done pulse
   always_ff @(posedge clk or negedge r_rst_n) begin
      if (!r_rst_n) begin
         r_state     <= c_IDLE;
         r_addr      <= '0;
         r_remaining <= '0;
      end else begin
         case (r_state)
            c_IDLE: begin
               if (i_start && i_inited) begin
                  r_addr      <= BASE_ADDR;
                  r_remaining <= c_RW'(FRAME_BEATS);
                  r_state     <= c_ISSUE;
               end
            end
            c_ISSUE: begin
               if (w_ar_hs) begin
                  r_addr      <= r_addr + w_addr_inc;
                  r_remaining <= r_remaining - c_RW'(w_this_len);
                  if (r_remaining == c_RW'(w_this_len)) begin
                     r_state <= c_DRAIN;
                  end
               end
            end
            c_DRAIN: begin
               if (r_outstanding == '0) begin
                  r_state <= c_DONE;
               end
            end
            default: begin
               r_state <= c_IDLE;
            end
         endcase
      end
   end

   // Beats requested but not yet received
   always_ff @(posedge clk or negedge r_rst_n) begin
      if (!r_rst_n) begin
         r_outstanding <= '0;
      end else begin
         r_outstanding <= r_outstanding + w_out_add - w_out_sub;
      end
   end

   // Show-ahead FIFO pointers and occupancy
   always_ff @(posedge clk or negedge r_rst_n) begin
      if (!r_rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_beat_acc) begin
            r_wr_ptr <= r_wr_ptr + c_AW'(1);
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + c_AW'(1);
         end
         if (w_beat_acc && !w_pop) begin
            r_count <= r_count + c_CW'(1);
         end else if (!w_beat_acc && w_pop) begin
            r_count <= r_count - c_CW'(1);
         end
      end
   end

   // FIFO storage; contents need no reset because o_data is gated by o_valid
   always_ff @(posedge clk) begin
      if (w_beat_acc) begin
         r_mem[r_wr_ptr] <= axi_rdata;
      end
   end

`ifdef DDR3_FRAME_READER_RLAST_CHECK_EN
   // ------------------------------------------------------------------------
   // Burst framing checker: lengths queued in issue order, compared with rlast
   // ------------------------------------------------------------------------
   logic [3:0]       r_lq_mem [FIFO_DEPTH];
   logic [c_AW-1:0]  r_lq_wr;
   logic [c_AW-1:0]  r_lq_rd;
   logic [3:0]       r_beat_cnt;
   logic             r_err;
   logic             w_exp_last;

   // At most one queued burst per outstanding beat, so FIFO_DEPTH entries suffice
   assign w_exp_last = (r_beat_cnt == r_lq_mem[r_lq_rd]);
   assign o_err      = r_err;

   // Record arlen of every accepted request
   always_ff @(posedge clk) begin
      if (w_ar_hs) begin
         r_lq_mem[r_lq_wr] <= axi_arlen;
      end
   end

   // Track beat position within the current burst and latch framing errors
   always_ff @(posedge clk or negedge r_rst_n) begin
      if (!r_rst_n) begin
         r_lq_wr    <= '0;
         r_lq_rd    <= '0;
         r_beat_cnt <= '0;
         r_err      <= 1'b0;
      end else begin
         if (w_ar_hs) begin
            r_lq_wr <= r_lq_wr + c_AW'(1);
         end
         if (w_beat_acc) begin
            if (w_exp_last) begin
               r_lq_rd    <= r_lq_rd + c_AW'(1);
               r_beat_cnt <= '0;
            end else begin
               r_beat_cnt <= r_beat_cnt + 4'd1;
            end
            if (axi_rlast != w_exp_last) begin
               r_err <= 1'b1;
            end
         end
         if (axi_rvalid && (r_outstanding == '0)) begin
            r_err <= 1'b1;
         end
      end
   end
`else
   logic w_unused_rlast;

   assign w_unused_rlast = axi_rlast;
   assign o_err          = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_ddr3_frame_reader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ddr3_frame_reader
//  Description : Self-checking bench for ddr3_frame_reader. A table of frame
//                scenarios drives an AR/R responder model; expected AR
//                requests and stream beats are queued and compared as the
//                DUT produces them. Hand-written sequences cover init gating
//                and reset mid-frame.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ddr3_frame_reader;

   localparam logic [27:0] BASE  = 28'hFFFFFC0;  // second burst wraps past 2^28
   localparam int          FB    = 100;
   localparam int          BL    = 16;
   localparam int          STEP  = 8;
   localparam int          DEPTH = 64;
`ifdef DDR3_FRAME_READER_RLAST_CHECK_EN
   localparam bit          ERR_EXP = 1'b1;
`else
   localparam bit          ERR_EXP = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rstn = 1'b1;
   logic          i_inited = 1'b1;
   logic          i_start = 1'b0;
   logic          o_busy, o_done, o_err;
   logic [27:0]   axi_araddr;
   logic [3:0]    axi_arlen;
   logic          axi_arvalid;
   logic          axi_arready = 1'b0;
   logic [127:0]  axi_rdata = '0;
   logic [3:0]    axi_rid = '0;
   logic          axi_rlast = 1'b0;
   logic          axi_rvalid = 1'b0;
   logic [127:0]  o_data;
   logic          o_valid;
   logic          i_ready = 1'b0;

   ddr3_frame_reader #(
      .BASE_ADDR   (BASE),
      .FRAME_BEATS (FB),
      .BURST_LEN   (BL),
      .ADDR_STEP   (STEP),
      .FIFO_DEPTH  (DEPTH)
   ) dut (
      .clk         (clk),
      .rstn        (rstn),
      .i_inited    (i_inited),
      .i_start     (i_start),
      .o_busy      (o_busy),
      .o_done      (o_done),
      .o_err       (o_err),
      .axi_araddr  (axi_araddr),
      .axi_arlen   (axi_arlen),
      .axi_arvalid (axi_arvalid),
      .axi_arready (axi_arready),
      .axi_rdata   (axi_rdata),
      .axi_rid     (axi_rid),
      .axi_rlast   (axi_rlast),
      .axi_rvalid  (axi_rvalid),
      .o_data      (o_data),
      .o_valid     (o_valid),
      .i_ready     (i_ready)
   );

   always #5 clk = ~clk;

   typedef struct {
      int         ar_delay;    // cycles arvalid waits before arready
      int         ready_mode;  // 0 always, 1 random, 2 held low then released
      bit         gaps;        // idle cycles between R beats
      bit         start_busy;  // extra i_start pulse mid-frame
      bit         inject;      // early rlast on beat 8 of first 16-beat burst
      int         exp_ars;
      logic [3:0] exp_last_len;
      bit         exp_err;
   } vec_t;

   typedef struct {
      int len;
      int t;
   } burst_t;

   vec_t          vec [6];
   burst_t        pend_q [$];
   logic [31:0]   exp_ar_q [$];
   logic [127:0]  exp_d_q [$];

   int            n_chk = 0;
   int            n_pass = 0;
   int            cyc = 0;
   int            ar_count = 0;
   int            done_count = 0;
   int            beats_out = 0;
   int            ar_wait = 0;
   int            beat_idx = 0;
   int            cur_delay = 0;
   int            cur_mode = 0;
   bit            cur_gaps = 1'b0;
   bit            inj_arm = 1'b0;
   bit            ready_hold = 1'b0;
   bit            prev_wait = 1'b0;
   logic [31:0]   hold_ar = '0;
   logic [3:0]    last_arlen = '0;
   logic [127:0]  d;
   logic [31:0]   e;

   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
   endtask

   task automatic chk_fail(input string nm, input logic [127:0] act);
      n_chk++;
      $display("FAIL %s: got %0h with nothing expected", nm, act);
   endtask

   // Reference list of AR requests for one frame
   task automatic build_ar();
      logic [27:0] a;
      int          rem;
      int          l;
      a   = BASE;
      rem = FB;
      exp_ar_q.delete();
      while (rem > 0) begin
         l = (rem > BL) ? BL : rem;
         exp_ar_q.push_back({a, 4'(l - 1)});
         a   = a + 28'(l * STEP);
         rem = rem - l;
      end
   endtask

   // Controller and pixel-pipeline model; drives at negedge, samples settled outputs
   always @(negedge clk) begin
      cyc++;
      if (!rstn) begin
         axi_arready = 1'b0;
         axi_rvalid  = 1'b0;
         axi_rlast   = 1'b0;
         i_ready     = 1'b0;
         ar_wait     = 0;
         prev_wait   = 1'b0;
         beat_idx    = 0;
      end else begin
         // AR channel
         if (prev_wait && !axi_arvalid) chk("arvalid_held", axi_arvalid, 1'b1);
         if (axi_arvalid) begin
            if (prev_wait) chk("ar_stable", {axi_araddr, axi_arlen}, hold_ar);
            axi_arready = (ar_wait >= cur_delay);
            if (axi_arready) begin
               if (exp_ar_q.size() == 0) chk_fail("ar_unexpected", {axi_araddr, axi_arlen});
               else begin
                  e = exp_ar_q.pop_front();
                  chk("ar_addr", axi_araddr, e[31:4]);
                  chk("ar_len", axi_arlen, e[3:0]);
               end
               pend_q.push_back('{len: int'(axi_arlen) + 1, t: cyc + 2});
               ar_count++;
               last_arlen = axi_arlen;
               ar_wait    = 0;
               prev_wait  = 1'b0;
            end else begin
               ar_wait++;
               prev_wait = 1'b1;
               hold_ar   = {axi_araddr, axi_arlen};
            end
         end else begin
            axi_arready = 1'b0;
            prev_wait   = 1'b0;
         end
         // R channel
         if (pend_q.size() > 0 && cyc >= pend_q[0].t &&
             (!cur_gaps || $urandom_range(3) != 0)) begin
            d = {$urandom, $urandom, $urandom, $urandom};
            axi_rvalid = 1'b1;
            axi_rdata  = d;
            axi_rid    = 4'(beat_idx);
            axi_rlast  = (beat_idx == pend_q[0].len - 1);
            if (inj_arm && pend_q[0].len == 16 && beat_idx == 7) begin
               axi_rlast = 1'b1;
               inj_arm   = 1'b0;
            end
            exp_d_q.push_back(d);
            beat_idx++;
            if (beat_idx == pend_q[0].len) begin
               beat_idx = 0;
               void'(pend_q.pop_front());
            end
         end else begin
            axi_rvalid = 1'b0;
            axi_rlast  = 1'b0;
         end
         // Stream consumer
         case (cur_mode)
            0:       i_ready = 1'b1;
            1:       i_ready = ($urandom_range(1) == 1);
            default: i_ready = ready_hold;
         endcase
         if (o_valid && i_ready) begin
            beats_out++;
            if (exp_d_q.size() == 0) chk_fail("stream_unexpected", o_data);
            else chk("stream_data", o_data, exp_d_q.pop_front());
         end
         if (o_done) done_count++;
      end
   end

   task automatic run_vec(input int i);
      int guard;
      cur_delay  = vec[i].ar_delay;
      cur_mode   = vec[i].ready_mode;
      cur_gaps   = vec[i].gaps;
      ready_hold = 1'b0;
      inj_arm    = vec[i].inject;
      build_ar();
      ar_count   = 0;
      done_count = 0;
      beats_out  = 0;
      @(negedge clk); i_start = 1'b1;
      @(negedge clk); i_start = 1'b0;
      chk("busy_after_start", o_busy, 1'b1);
      if (vec[i].start_busy) begin
         repeat (8) @(negedge clk);
         i_start = 1'b1;
         @(negedge clk); i_start = 1'b0;
      end
      if (cur_mode == 2) begin
         repeat (300) @(negedge clk);
         chk("bp_ar_count", ar_count, 4);
         chk("bp_arvalid", axi_arvalid, 1'b0);
         chk("bp_valid", o_valid, 1'b1);
         ready_hold = 1'b1;
      end
      guard = 0;
      while (done_count == 0 && guard < 5000) begin
         @(negedge clk); guard++;
      end
      chk("done_in_time", guard < 5000, 1'b1);
      guard = 0;
      while (exp_d_q.size() != 0 && guard < 2000) begin
         @(negedge clk); guard++;
      end
      repeat (10) @(negedge clk);
      chk("frame_ar_count", ar_count, vec[i].exp_ars);
      chk("last_arlen", last_arlen, vec[i].exp_last_len);
      chk("done_pulses", done_count, 1);
      chk("stream_beats", beats_out, FB);
      chk("ar_left", exp_ar_q.size(), 0);
      chk("stream_left", exp_d_q.size(), 0);
      chk("busy_end", o_busy, 1'b0);
      chk("valid_end", o_valid, 1'b0);
      chk("err", o_err, vec[i].exp_err);
   endtask

   initial begin
      int guard;
      vec[0] = '{0, 0, 1'b0, 1'b0, 1'b0, 7, 4'd3, 1'b0};
      vec[1] = '{0, 1, 1'b1, 1'b0, 1'b0, 7, 4'd3, 1'b0};
      vec[2] = '{0, 2, 1'b0, 1'b0, 1'b0, 7, 4'd3, 1'b0};
      vec[3] = '{5, 0, 1'b0, 1'b1, 1'b0, 7, 4'd3, 1'b0};
      vec[4] = '{0, 0, 1'b0, 1'b0, 1'b1, 7, 4'd3, ERR_EXP};
      vec[5] = '{0, 1, 1'b1, 1'b0, 1'b0, 7, 4'd3, ERR_EXP};

      #1 rstn = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_busy", o_busy, 1'b0);
      chk("rst_done", o_done, 1'b0);
      chk("rst_err", o_err, 1'b0);
      chk("rst_arvalid", axi_arvalid, 1'b0);
      chk("rst_araddr", axi_araddr, 28'h0);
      chk("rst_arlen", axi_arlen, 4'h0);
      chk("rst_valid", o_valid, 1'b0);
      chk("rst_data", o_data, 128'h0);
      rstn = 1'b1;
      repeat (4) @(negedge clk);

      for (int i = 0; i < 6; i++) run_vec(i);

      // Start ignored while the controller is not initialised
      cur_mode = 0; cur_delay = 0; cur_gaps = 1'b0;
      exp_ar_q.delete();
      ar_count = 0;
      i_inited = 1'b0;
      @(negedge clk); i_start = 1'b1;
      @(negedge clk); i_start = 1'b0;
      repeat (20) @(negedge clk);
      chk("noinit_ar_count", ar_count, 0);
      chk("noinit_busy", o_busy, 1'b0);
      chk("noinit_arvalid", axi_arvalid, 1'b0);
      i_inited = 1'b1;

      // Reset in the middle of a frame
      build_ar();
      ar_count = 0;
      @(negedge clk); i_start = 1'b1;
      @(negedge clk); i_start = 1'b0;
      guard = 0;
      while (ar_count < 2 && guard < 500) begin
         @(negedge clk); guard++;
      end
      chk("midrst_progress", ar_count >= 2, 1'b1);
      @(posedge clk); #2;
      rstn = 1'b0;
      #1;
      chk("midrst_busy", o_busy, 1'b0);
      chk("midrst_done", o_done, 1'b0);
      chk("midrst_err", o_err, 1'b0);
      chk("midrst_arvalid", axi_arvalid, 1'b0);
      chk("midrst_araddr", axi_araddr, 28'h0);
      chk("midrst_arlen", axi_arlen, 4'h0);
      chk("midrst_valid", o_valid, 1'b0);
      chk("midrst_data", o_data, 128'h0);
      axi_rvalid = 1'b0;
      axi_rlast  = 1'b0;
      pend_q.delete();
      exp_d_q.delete();
      exp_ar_q.delete();
      beat_idx = 0;
      repeat (3) @(negedge clk);
      rstn = 1'b1;
      repeat (4) @(negedge clk);
      run_vec(0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, %0d checks so far", n_chk);
      $fatal(1, "watchdog");
   end

endmodule
`default_nettype wire
